// File: rtl/state_trace_pkg.sv
// Shared defaults, trace entry layout and pointer sizing for the state trace buffer.
package state_trace_pkg;

  localparam int unsigned STATE_W_DEFAULT = 5;
  localparam int unsigned TS_W_DEFAULT    = 16;

  typedef struct packed {
    logic [TS_W_DEFAULT-1:0]    ts;
    logic [STATE_W_DEFAULT-1:0] state;
  } trace_entry_t;

  // One extra pointer bit separates full from empty when the index bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO holding captured trace entries.
// Synchronous active-low reset; clr flushes both pointers and wins over push/pop.
module trace_fifo
  import state_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  entry_t               wr_data_i,
  input  logic                 pop_i,
  output entry_t               rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned IDX_W = PTR_W - 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is not reset; the head is masked while empty so it reads 0 after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push && !clr_i) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/state_trace_buffer.sv
// Records every change of the observed FSM state with a cycle timestamp into a FIFO.
// Optional cycle-limit halt enabled by defining STATE_TRACE_HALT_EN.
module state_trace_buffer
  import state_trace_pkg::*;
#(
  parameter int unsigned STATE_W    = STATE_W_DEFAULT,
  parameter int unsigned TS_W       = TS_W_DEFAULT,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STATE_W-1:0]        state_in,
  input  logic                      trace_en,
  input  logic                      clr,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_W+STATE_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_count,
  output logic                      halt
);

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [STATE_W-1:0] state;
  } entry_t;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [STATE_W-1:0] prev_q;
  logic               first_q, first_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;
  logic               halt_w;
  logic               capture;
  logic               pop;
  logic               push;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             wr_entry;
  entry_t             head;

  assign capture  = trace_en && (first_q || (state_in != prev_q)) && !halt_w;
  assign pop      = rd_valid && rd_ready;
  assign push     = capture && (!fifo_full || pop);
  assign drop     = capture && fifo_full && !pop;
  assign wr_entry = '{ts: ts_q, state: state_in};

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (clr),
    .push_i    (push),
    .wr_data_i (wr_entry),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rd_valid   = !fifo_empty;
  assign rd_data    = head;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

  always_comb begin
    ts_d       = ts_q + TS_W'(1);
    first_d    = first_q && !trace_en;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr) begin
      overflow_d = 1'b0;
      drop_d     = 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= state_in;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

`ifdef STATE_TRACE_HALT_EN
  localparam int unsigned CYC_W = $clog2(MAX_CYCLES + 1);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             halt_q, halt_d;

  // Halt rises on the edge where the counter reaches the limit; counter then freezes.
  always_comb begin
    cyc_d  = cyc_q;
    halt_d = halt_q;
    if (!halt_q) begin
      cyc_d  = cyc_q + CYC_W'(1);
      halt_d = (cyc_d == CYC_W'(MAX_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q  <= '0;
      halt_q <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      halt_q <= halt_d;
    end
  end

  assign halt_w = halt_q;
  assign halt   = halt_q;
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign halt_w = 1'b0;
  assign halt   = 1'b0;
`endif

endmodule

// File: tb/tb_state_trace_buffer.sv
// Self-checking bench for state_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_state_trace_buffer;

  localparam int unsigned STATE_W    = 5;
  localparam int unsigned TS_W       = 16;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned MAX_CYCLES = 63;
  localparam int unsigned EW         = TS_W + STATE_W;

`ifdef STATE_TRACE_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [STATE_W-1:0] state_in;
  logic               trace_en;
  logic               clr;
  logic               rd_valid;
  logic               rd_ready;
  logic [EW-1:0]      rd_data;
  logic [4:0]         count;
  logic               overflow;
  logic [7:0]         drop_count;
  logic               halt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [EW-1:0]      m_q[$];
  int                 m_ts;
  logic [STATE_W-1:0] m_prev;
  bit                 m_first;
  bit                 m_ovf;
  int                 m_drop;
  int                 m_cyc;
  bit                 m_halt;

  state_trace_buffer #(
    .STATE_W    (STATE_W),
    .TS_W       (TS_W),
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .state_in   (state_in),
    .trace_en   (trace_en),
    .clr        (clr),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .halt       (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one clock edge's worth of the behavioural rules to the model.
  task automatic model_step();
    bit cap;
    bit popv;
    if (!reset) begin
      m_q.delete();
      m_ts = 0; m_prev = '0; m_first = 1'b1; m_ovf = 1'b0; m_drop = 0;
      m_cyc = 0; m_halt = 1'b0;
      return;
    end
    cap  = trace_en && (m_first || state_in != m_prev) && !m_halt;
    popv = rd_ready && (m_q.size() > 0);
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (popv) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < DEPTH) m_q.push_back({16'(m_ts), state_in});
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    m_prev = state_in;
    if (trace_en) m_first = 1'b0;
    m_ts = (m_ts + 1) % 65536;
    if (HALT_EN && !m_halt) begin
      m_cyc++;
      if (m_cyc == MAX_CYCLES) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; clr = 1'b0; trace_en = 1'b0; rd_ready = 1'b0; state_in = '0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", rd_valid); end
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", rd_data); end
    n_tests++; if (overflow !== 1'b0 || drop_count !== 8'd0 || halt !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovf=%b drop=%0d halt=%b exp 0/0/0", overflow, drop_count, halt);
    end
  endtask

  task automatic test_first_entry();
    trace_en = 1'b1; state_in = 5'd0;
    tick();
    n_tests++; if (rd_valid !== 1'b1 || count !== 5'd1) begin
      n_fail++; $display("FAIL first_entry: got valid=%b count=%0d exp 1/1", rd_valid, count);
    end
    n_tests++; if (rd_data !== 21'd0) begin n_fail++; $display("FAIL first_data: got %h exp 0", rd_data); end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL first_hold: got %0d exp 1", count); end
  endtask

  task automatic test_sequence();
    logic [STATE_W-1:0] seq [5];
    logic [EW-1:0]      exp_e [4];
    seq[0] = 5'd0; seq[1] = 5'd1; seq[2] = 5'd1; seq[3] = 5'd2; seq[4] = 5'd3;
    exp_e[0] = {16'd0, 5'd0}; exp_e[1] = {16'd1, 5'd1};
    exp_e[2] = {16'd3, 5'd2}; exp_e[3] = {16'd4, 5'd3};
    do_reset(2);
    trace_en = 1'b1;
    for (int i = 0; i < 5; i++) begin state_in = seq[i]; tick(); end
    n_tests++; if (count !== 5'd4) begin n_fail++; $display("FAIL seq_count: got %0d exp 4", count); end
    trace_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rd_data !== exp_e[k]) begin
        n_fail++; $display("FAIL seq_entry%0d: got %h exp %h", k, rd_data, exp_e[k]);
      end
      rd_ready = 1'b1; tick();
    end
    rd_ready = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL seq_drained: got %b exp 0", rd_valid); end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [EW-1:0] exp_e;
    do_reset(2);
    trace_en = 1'b1;
    for (int i = 0; i < 20; i++) begin state_in = 5'(i + 1); tick(); end
    n_tests++; if (count !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd4) begin
      n_fail++; $display("FAIL ovf: got count=%0d ovf=%b drop=%0d exp 16/1/4", count, overflow, drop_count);
    end
    // Capture coinciding with a pop while full: accepted, no drop.
    state_in = 5'd30; rd_ready = 1'b1; tick();
    n_tests++; if (count !== 5'd16 || drop_count !== 8'd4) begin
      n_fail++; $display("FAIL full_pop: got count=%0d drop=%0d exp 16/4", count, drop_count);
    end
    trace_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_e = (k < 15) ? {16'(k + 1), 5'(k + 2)} : {16'd20, 5'd30};
      n_tests++; if (rd_data !== exp_e) begin
        n_fail++; $display("FAIL ovf_entry%0d: got %h exp %h", k, rd_data, exp_e);
      end
      tick();
    end
    rd_ready = 1'b0;
    n_tests++; if (count !== 5'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drained: got count=%0d valid=%b exp 0/0", count, rd_valid);
    end
  endtask

  task automatic test_clr();
    do_reset(2);
    trace_en = 1'b1;
    for (int i = 0; i < 17; i++) begin state_in = 5'(i + 1); tick(); end
    trace_en = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    rd_ready = 1'b0;
    n_tests++; if (count !== 5'd5 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL pre_clr: got count=%0d ovf=%b exp 5/1", count, overflow);
    end
    clr = 1'b1; trace_en = 1'b1; rd_ready = 1'b1; state_in = 5'd25; tick();
    clr = 1'b0; rd_ready = 1'b0;
    n_tests++; if (count !== 5'd0 || overflow !== 1'b0 || drop_count !== 8'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr: got count=%0d ovf=%b drop=%0d valid=%b exp 0/0/0/0", count, overflow, drop_count, rd_valid);
    end
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL clr_no_rearm: got %0d exp 0", count); end
    state_in = 5'd26; tick();
    n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL clr_after: got %0d exp 1", count); end
  endtask

  task automatic test_reset_mid();
    trace_en = 1'b1;
    for (int i = 0; i < 18; i++) begin state_in = 5'(i); tick(); end
    n_tests++; if (overflow !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL mid_pre: got ovf=%b count=%0d exp 1/16", overflow, count);
    end
    reset = 1'b0; tick(); reset = 1'b1; trace_en = 1'b0;
    n_tests++; if (rd_valid !== 1'b0 || count !== 5'd0 || rd_data !== '0 ||
                   overflow !== 1'b0 || drop_count !== 8'd0 || halt !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b count=%0d data=%h ovf=%b drop=%0d halt=%b exp all 0",
                         rd_valid, count, rd_data, overflow, drop_count, halt);
    end
  endtask

  task automatic test_halt();
    bit exp_h;
    do_reset(2);
    trace_en = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      state_in = 5'(k * 7 + 3);
      tick();
      exp_h = HALT_EN && (k + 1 >= int'(MAX_CYCLES));
      n_tests++; if (halt !== exp_h) begin
        n_fail++; $display("FAIL halt_c%0d: got %b exp %b", k, halt, exp_h);
      end
      n_tests++; if (count !== 5'(m_q.size())) begin
        n_fail++; $display("FAIL halt_count_c%0d: got %0d exp %0d", k, count, m_q.size());
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset(2);
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 149) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      trace_en = ($urandom_range(0, 7) != 0);
      rd_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) state_in = 5'($urandom_range(0, 31));
      tick();
      n_tests++; if (count !== 5'(m_q.size())) begin
        n_fail++; $display("FAIL rnd_count_c%0d: got %0d exp %0d", k, count, m_q.size());
      end
      n_tests++; if (rd_valid !== (m_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid_c%0d: got %b exp %b", k, rd_valid, m_q.size() > 0);
      end
      if (m_q.size() > 0) begin
        n_tests++; if (rd_data !== m_q[0]) begin
          n_fail++; $display("FAIL rnd_data_c%0d: got %h exp %h", k, rd_data, m_q[0]);
        end
      end
      n_tests++; if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
        n_fail++; $display("FAIL rnd_drop_c%0d: got ovf=%b drop=%0d exp %b/%0d", k, overflow, drop_count, m_ovf, m_drop);
      end
      n_tests++; if (halt !== m_halt) begin
        n_fail++; $display("FAIL rnd_halt_c%0d: got %b exp %b", k, halt, m_halt);
      end
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; trace_en = 1'b0; rd_ready = 1'b0; state_in = '0;
    m_ts = 0; m_prev = '0; m_first = 1'b1; m_ovf = 1'b0; m_drop = 0; m_cyc = 0; m_halt = 1'b0;
    test_reset();
    test_first_entry();
    test_sequence();
    test_overflow_and_full_pop();
    test_clr();
    test_reset_mid();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
